sdram_tile_loader: RTL and testbench

Command-driven loader that sits directly downstream of the HPS-side SDRAM read wrapper. It accepts a "copy N beats from SDRAM byte address A into local buffer word address B" command and splits N into bursts of at most MAX_BURST beats. For each burst it drives the wrapper's start/addr/cnt read port, and it writes every returned 128-bit beat into the NPU's local buffer RAM at an incrementing address.

---
 rtl/sdram_tile_loader.sv | 158 +++++++++++++++
 tb/tb_sdram_tile_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_tile_loader.sv
// Command-driven SDRAM-to-local-buffer loader: splits a beat count into wrapper bursts of at
// most MAX_BURST beats and streams every returned beat into the buffer at an incrementing address.
module sdram_tile_loader #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned CNT_W     = 11,
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned BUF_AW    = 10,
   parameter int unsigned MAX_BURST = 256
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_sdram_addr,
   input  logic [BUF_AW-1:0] cmd_buf_addr,
   input  logic [15:0]       cmd_beats,
   output logic              read_start,
   output logic [ADDR_W-1:0] read_addr,
   output logic [CNT_W-1:0]  read_cnt,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_valid,
   input  logic              read_done,
   output logic              buf_we,
   output logic [BUF_AW-1:0] buf_addr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {StIdle, StIssue, StRecv, StFin} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   read_addr_q, read_addr_d;
   logic [CNT_W-1:0]    read_cnt_q, read_cnt_d;
   logic [15:0]         remaining_q, remaining_d;
   logic [CNT_W-1:0]    rx_q, rx_d;
   logic [BUF_AW-1:0]   buf_ptr_q, buf_ptr_d;
   logic                err_q, err_d;
   logic                buf_we_q, buf_we_d;
   logic [BUF_AW-1:0]   buf_addr_q, buf_addr_d;
   logic [DATA_W-1:0]   buf_wdata_q, buf_wdata_d;

   logic                take;
   logic [CNT_W-1:0]    rx_inc;
   logic [15:0]         rem_next;

   function automatic logic [CNT_W-1:0] burst_len(input logic [15:0] n);
      if (n > 16'(MAX_BURST)) return CNT_W'(MAX_BURST);
      return CNT_W'(n);
   endfunction

   // read_cnt_q doubles as the current chunk size: it holds for the whole burst.
   assign take     = (state_q == StRecv) && read_valid && (rx_q != read_cnt_q);
   assign rx_inc   = rx_q + CNT_W'(take);
   assign rem_next = remaining_q - 16'(read_cnt_q);

   always_comb begin
      state_d     = state_q;
      read_addr_d = read_addr_q;
      read_cnt_d  = read_cnt_q;
      remaining_d = remaining_q;
      rx_d        = rx_q;
      buf_ptr_d   = buf_ptr_q;
      err_d       = err_q;
      buf_we_d    = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_wdata_d = buf_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               err_d       = 1'b0;
               remaining_d = cmd_beats;
               buf_ptr_d   = cmd_buf_addr;
               if (cmd_beats == 16'd0) begin
                  state_d = StFin;
               end else begin
                  read_addr_d = cmd_sdram_addr & ~ADDR_W'(15);
                  read_cnt_d  = burst_len(cmd_beats);
                  state_d     = StIssue;
               end
            end
         end
         StIssue: begin
            rx_d    = '0;
            state_d = StRecv;
         end
         StRecv: begin
            if (take) begin
               buf_we_d    = 1'b1;
               buf_addr_d  = buf_ptr_q;
               buf_wdata_d = read_data;
               buf_ptr_d   = buf_ptr_q + 1'b1;
               rx_d        = rx_inc;
            end
            if (read_done) begin
               if (rx_inc == read_cnt_q) begin
                  remaining_d = rem_next;
                  if (rem_next != 16'd0) begin
                     read_addr_d = read_addr_q + (ADDR_W'(read_cnt_q) << 4);
                     read_cnt_d  = burst_len(rem_next);
                     state_d     = StIssue;
                  end else begin
                     state_d = StFin;
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = StFin;
               end
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // A beat nobody asked for is dropped and flagged, even on the accept cycle.
      if (read_valid && !take) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         read_addr_q <= '0;
         read_cnt_q  <= '0;
         remaining_q <= '0;
         rx_q        <= '0;
         buf_ptr_q   <= '0;
         err_q       <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         read_addr_q <= read_addr_d;
         read_cnt_q  <= read_cnt_d;
         remaining_q <= remaining_d;
         rx_q        <= rx_d;
         buf_ptr_q   <= buf_ptr_d;
         err_q       <= err_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_wdata_q <= buf_wdata_d;
      end
   end

   assign cmd_ready  = (state_q == StIdle);
   assign read_start = (state_q == StIssue);
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFin);
   assign read_addr  = read_addr_q;
   assign read_cnt   = read_cnt_q;
   assign buf_we     = buf_we_q;
   assign buf_addr   = buf_addr_q;
   assign buf_wdata  = buf_wdata_q;
   assign err        = err_q;

endmodule

// File: tb/tb_sdram_tile_loader.sv
// Directed bench for sdram_tile_loader: a table of commands replayed against a behavioural
// read wrapper, plus hand sequences for short bursts and reset mid-burst.
module tb_sdram_tile_loader;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_valid, cmd_ready;
   logic [31:0]   cmd_sdram_addr;
   logic [9:0]    cmd_buf_addr;
   logic [15:0]   cmd_beats;
   logic          read_start;
   logic [31:0]   read_addr;
   logic [10:0]   read_cnt;
   logic [127:0]  read_data;
   logic          read_valid, read_done;
   logic          buf_we;
   logic [9:0]    buf_addr;
   logic [127:0]  buf_wdata;
   logic          busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdram_tile_loader #(
      .ADDR_W(32), .CNT_W(11), .DATA_W(128), .BUF_AW(10), .MAX_BURST(256)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sdram_addr(cmd_sdram_addr), .cmd_buf_addr(cmd_buf_addr), .cmd_beats(cmd_beats),
      .read_start(read_start), .read_addr(read_addr), .read_cnt(read_cnt),
      .read_data(read_data), .read_valid(read_valid), .read_done(read_done),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [9:0]  bufa;
      logic [15:0] beats;
      logic        same;       // last valid coincides with read_done
      int          bursts;
      logic [31:0] last_addr;
      logic [10:0] last_cnt;
      int          writes;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] pat(input int i);
      logic [31:0] x;
      x = 32'(i);
      return {x ^ 32'hC0DE_0000, ~x, x * 32'd3, x + 32'h1234_5678};
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1'b1));
      chk({tag, "_read_start"}, 128'(read_start), 128'(1'b0));
      chk({tag, "_read_addr"}, 128'(read_addr), 128'(0));
      chk({tag, "_read_cnt"}, 128'(read_cnt), 128'(0));
      chk({tag, "_buf_we"}, 128'(buf_we), 128'(1'b0));
      chk({tag, "_buf_addr"}, 128'(buf_addr), 128'(0));
      chk({tag, "_buf_wdata"}, buf_wdata, 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(1'b0));
      chk({tag, "_done"}, 128'(done), 128'(1'b0));
      chk({tag, "_err"}, 128'(err), 128'(1'b0));
   endtask

   // short_n < 0: wrapper returns the full burst; otherwise exactly short_n beats per burst.
   task automatic run_cmd(input vec_t v, input int short_n, input logic exp_err);
      int          gen = 0, wr = 0, starts = 0, dones = 0, timing_bad = 0;
      int          last_done_it = -10, finish_it = -1, send_left = 0;
      bit          done_pend = 1'b0, prev_valid = 1'b0, pv;
      logic [31:0] exp_addr, last_addr = '0;
      logic [15:0] rem;
      logic [9:0]  exp_ptr;
      logic [10:0] exp_cnt, last_cnt = '0;
      exp_addr = v.addr & 32'hFFFF_FFF0;
      rem      = v.beats;
      exp_ptr  = v.bufa;
      chk("cmd_ready", 128'(cmd_ready), 128'(1'b1));
      cmd_valid      = 1'b1;
      cmd_sdram_addr = v.addr;
      cmd_buf_addr   = v.bufa;
      cmd_beats      = v.beats;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int it = 0; it < 2000; it++) begin
         pv         = prev_valid;
         prev_valid = 1'b0;
         read_valid = 1'b0;
         read_done  = 1'b0;
         if (send_left > 0) begin
            read_valid = 1'b1;
            read_data  = pat(gen);
            gen++;
            send_left--;
            prev_valid = 1'b1;
            if (send_left == 0) begin
               if (v.same) begin
                  read_done    = 1'b1;
                  last_done_it = it;
               end else begin
                  done_pend = 1'b1;
               end
            end
         end else if (done_pend) begin
            read_done    = 1'b1;
            done_pend    = 1'b0;
            last_done_it = it;
         end
         if (it == 0) begin
            chk("first_cycle", 128'((v.beats == 16'd0) ? done : read_start), 128'(1'b1));
            chk("busy_on", 128'(busy), 128'(1'b1));
            chk("err_cleared", 128'(err), 128'(1'b0));
         end
         if (buf_we !== pv) timing_bad++;
         if (buf_we === 1'b1) begin
            chk("buf_addr", 128'(buf_addr), 128'(exp_ptr));
            chk("buf_wdata", buf_wdata, pat(wr));
            exp_ptr++;
            wr++;
         end
         if (read_start === 1'b1) begin
            starts++;
            if (it != 0 && last_done_it != it - 1) timing_bad++;
            exp_cnt = (rem > 16'd256) ? 11'd256 : rem[10:0];
            chk("read_addr", 128'(read_addr), 128'(exp_addr));
            chk("read_cnt", 128'(read_cnt), 128'(exp_cnt));
            last_addr = read_addr;
            last_cnt  = read_cnt;
            exp_addr += {17'b0, exp_cnt, 4'b0};
            rem      -= {5'b0, exp_cnt};
            send_left = (short_n >= 0) ? short_n : int'(exp_cnt);
            done_pend = (send_left == 0);
         end
         if (done === 1'b1) begin
            dones++;
            if (!(it == 0 && v.beats == 16'd0) && last_done_it != it - 1) timing_bad++;
            finish_it = it;
         end
         if (finish_it >= 0 && it == finish_it + 1) chk("busy_off", 128'(busy), 128'(1'b0));
         if (finish_it >= 0 && it == finish_it + 3) break;
         @(negedge clk);
      end
      read_valid = 1'b0;
      read_done  = 1'b0;
      chk("starts", 128'(starts), 128'(v.bursts));
      chk("writes", 128'(wr), 128'(v.writes));
      chk("dones", 128'(dones), 128'(1));
      chk("timing", 128'(timing_bad), 128'(0));
      chk("err_end", 128'(err), 128'(exp_err));
      if (v.bursts > 0) begin
         chk("last_addr", 128'(last_addr), 128'(v.last_addr));
         chk("last_cnt", 128'(last_cnt), 128'(v.last_cnt));
      end
   endtask

   initial begin
      vec_t short_v;
      cmd_valid      = 1'b0;
      cmd_sdram_addr = '0;
      cmd_buf_addr   = '0;
      cmd_beats      = '0;
      read_valid     = 1'b0;
      read_done      = 1'b0;
      read_data      = '0;

      //              addr          buf     beats  same bursts last_addr     last_cnt writes
      tbl[0] = '{32'h0000_1000, 10'd0,    16'd4,   1'b0, 1, 32'h0000_1000, 11'd4,   4};
      tbl[1] = '{32'h0000_2000, 10'd0,    16'd600, 1'b0, 3, 32'h0000_4000, 11'd88,  600};
      tbl[2] = '{32'h0000_100F, 10'd5,    16'd1,   1'b0, 1, 32'h0000_1000, 11'd1,   1};
      tbl[3] = '{32'h0000_0000, 10'd7,    16'd0,   1'b0, 0, 32'h0000_0000, 11'd0,   0};
      tbl[4] = '{32'hFFFF_FF00, 10'd100,  16'd300, 1'b0, 2, 32'h0000_0F00, 11'd44,  300};
      tbl[5] = '{32'h0000_3000, 10'd1020, 16'd256, 1'b0, 1, 32'h0000_3000, 11'd256, 256};
      tbl[6] = '{32'h0000_8000, 10'd1022, 16'd4,   1'b1, 1, 32'h0000_8000, 11'd4,   4};

      #2;
      check_reset("rst");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_cmd(tbl[i], -1, 1'b0);

      // Short burst: 8 requested, 5 returned.
      short_v = '{32'h0000_6000, 10'd50, 16'd8, 1'b0, 1, 32'h0000_6000, 11'd8, 5};
      run_cmd(short_v, 5, 1'b1);
      run_cmd(tbl[0], -1, 1'b0);

      // Reset after 3 of 8 beats, then a stray beat.
      cmd_valid      = 1'b1;
      cmd_sdram_addr = 32'h0000_5000;
      cmd_buf_addr   = 10'd200;
      cmd_beats      = 16'd8;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("rst_seq_start", 128'(read_start), 128'(1'b1));
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         read_valid = 1'b1;
         read_data  = pat(k);
         @(negedge clk);
      end
      read_valid = 1'b0;
      chk("rst_seq_we", 128'(buf_we), 128'(1'b1));
      chk("rst_seq_addr", 128'(buf_addr), 128'(10'd202));
      reset_n = 1'b0;
      #1;
      check_reset("mid");
      @(negedge clk);
      reset_n    = 1'b1;
      read_valid = 1'b1;
      read_data  = pat(9);
      @(negedge clk);
      read_valid = 1'b0;
      chk("stray_err", 128'(err), 128'(1'b1));
      chk("stray_we", 128'(buf_we), 128'(1'b0));
      chk("stray_idle", 128'(cmd_ready), 128'(1'b1));
      @(negedge clk);
      run_cmd(tbl[2], -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
